ps2_keyboard_rx: RTL and testbench

//  PS/2 keyboard receiver and scancode FIFO feeding the CPU keyboard port (kb_ch/kb_hit/kb_tr).

---
 rtl/ps2_keyboard_rx.sv | 227 ++++++++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises and filters the PS/2 lines, deframes
// 11-bit frames (start, 8 data LSB first, odd parity, stop) and buffers raw
// scancode bytes in a small show-ahead FIFO read by the CPU keyboard port.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int FIFO_AW        = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       kb_tr,
  input  logic       kb_clr,
  output logic [7:0] kb_ch,
  output logic       kb_hit,
  output logic       kb_err,
  output logic       kb_ovf
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int FW    = $clog2(FILTER_LEN + 1);
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [FW-1:0]    FILT_LAST  = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0]    TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Input synchroniser and filter state
  logic          clk_meta, clk_sync;
  logic          data_meta, data_sync;
  logic          filt_clk, filt_prev;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  // Deframer state
  state_t        state, state_next;
  logic [2:0]    bit_cnt, bit_cnt_next;
  logic [7:0]    shift, shift_next;
  logic          perr, perr_next;
  logic          push;
  logic          frame_err;

  // Inter-edge timeout
  logic [TW-1:0] to_cnt;
  logic          timeout;

  // FIFO
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               tr_q;
  logic               pop_req, fifo_empty, fifo_full;
  logic               do_pop, do_push, ovf_set;

  // Two-stage synchronisers for the asynchronous PS/2 lines
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_meta  <= 1'b0;
      clk_sync  <= 1'b0;
      data_meta <= 1'b0;
      data_sync <= 1'b0;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  // Debounce the PS/2 clock: follow it only after FILTER_LEN differing samples
  always_ff @(posedge clock) begin
    if (reset) begin
      filt_clk  <= 1'b0;
      filt_prev <= 1'b0;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt_clk;
      if (clk_sync == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_clk <= clk_sync;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall = filt_prev & ~filt_clk;

  // Count idle cycles inside a frame; restart on each falling edge
  always_ff @(posedge clock) begin
    if (reset || state == IDLE || fall || timeout) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout = (state != IDLE) && !fall && (to_cnt == TO_LAST);

  // Deframer state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      perr    <= 1'b0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      shift   <= shift_next;
      perr    <= perr_next;
    end
  end

  // Deframer next state: advance on each filtered clock fall, abort on timeout
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shift_next   = shift;
    perr_next    = perr;
    push         = 1'b0;
    frame_err    = 1'b0;
    if (timeout) begin
      state_next = IDLE;
      frame_err  = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!data_sync) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end
        end
        DATA: begin
          shift_next   = {data_sync, shift[7:1]};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_next = PARITY;
          end
        end
        PARITY: begin
          perr_next  = ~(^shift ^ data_sync);
          state_next = STOP;
        end
        STOP: begin
          if (data_sync && !perr) begin
            push = 1'b1;
          end else begin
            frame_err = 1'b1;
          end
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign pop_req    = kb_tr & ~tr_q;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_COUNT);
  assign do_pop     = pop_req & ~fifo_empty;
  assign do_push    = push & (~fifo_full | do_pop);
  assign ovf_set    = push & fifo_full & ~do_pop;

  // FIFO pointers, occupancy and read-strobe edge detector
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      tr_q   <= 1'b0;
    end else begin
      tr_q <= kb_tr;
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

  // FIFO storage; contents are only visible while count says they are valid
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= shift;
    end
  end

  // Sticky error flags; a new event beats a simultaneous clear
  always_ff @(posedge clock) begin
    if (reset) begin
      kb_err <= 1'b0;
      kb_ovf <= 1'b0;
    end else begin
      if (frame_err) begin
        kb_err <= 1'b1;
      end else if (kb_clr) begin
        kb_err <= 1'b0;
      end
      if (ovf_set) begin
        kb_ovf <= 1'b1;
      end else if (kb_clr) begin
        kb_ovf <= 1'b0;
      end
    end
  end

  assign kb_hit = ~fifo_empty;
  assign kb_ch  = fifo_empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: drives PS/2 frames and CPU reads,
// and compares the keyboard port against a queue-based model of the FIFO.
module tb_ps2_keyboard_rx;

  localparam int FILTER_LEN = 4;
  localparam int TIMEOUT    = 2000;
  localparam int FIFO_AW    = 3;
  localparam int DEPTH      = 1 << FIFO_AW;
  localparam int PS2_HALF   = 20;
  localparam int PS2_GAP    = 20;
  // cycles from driving ps2_clk low to the clock edge that commits the fall
  localparam int FALL_LAT   = 2 + FILTER_LEN + 1;

  logic       clock = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic       kb_tr;
  logic       kb_clr;
  logic [7:0] kb_ch;
  logic       kb_hit;
  logic       kb_err;
  logic       kb_ovf;

  int         checks = 0;
  int         errors = 0;

  logic [7:0] model_q[$];
  logic       model_err;
  logic       model_ovf;

  int         op;
  logic [7:0] rnd_byte;

  ps2_keyboard_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT),
    .FIFO_AW       (FIFO_AW)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .kb_tr   (kb_tr),
    .kb_clr  (kb_clr),
    .kb_ch   (kb_ch),
    .kb_hit  (kb_hit),
    .kb_err  (kb_err),
    .kb_ovf  (kb_ovf)
  );

  // 25 MHz system clock
  always #20 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".hit"}, 32'(kb_hit), 32'(model_q.size() != 0));
    checkOutput({tag, ".ch"}, 32'(kb_ch), 32'((model_q.size() != 0) ? model_q[0] : 8'h00));
    checkOutput({tag, ".err"}, 32'(kb_err), 32'(model_err));
    checkOutput({tag, ".ovf"}, 32'(kb_ovf), 32'(model_ovf));
  endtask

  task automatic modelFrame(input logic [7:0] data, input bit ok, input bit pop_same);
    if (pop_same && model_q.size() > 0) void'(model_q.pop_front());
    if (!ok) model_err = 1'b1;
    else if (model_q.size() < DEPTH) model_q.push_back(data);
    else model_ovf = 1'b1;
  endtask

  task automatic modelReset();
    model_q.delete();
    model_err = 1'b0;
    model_ovf = 1'b0;
  endtask

  // Sends the first nbits bits of a frame; mode 1 raises kb_tr so the pop
  // lands on the stop fall, mode 2 checks the one-cycle push latency
  task automatic applyStimulus(input logic [7:0] data, input bit bad_par, input bit bad_stop,
                               input int mode, input int nbits);
    logic [10:0] frame;
    frame = {~bad_stop, (~^data) ^ bad_par, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      repeat (PS2_HALF) @(negedge clock);
      ps2_clk = 1'b0;
      if (i == 10 && mode == 1) begin
        repeat (FALL_LAT - 1) @(negedge clock);
        kb_tr = 1'b1;
        repeat (PS2_HALF - FALL_LAT + 1) @(negedge clock);
      end else if (i == 10 && mode == 2) begin
        repeat (FALL_LAT - 1) @(negedge clock);
        checkOutput("latency.pre_hit", 32'(kb_hit), 32'd0);
        @(negedge clock);
        checkOutput("latency.hit", 32'(kb_hit), 32'd1);
        checkOutput("latency.ch", 32'(kb_ch), 32'(data));
        repeat (PS2_HALF - FALL_LAT) @(negedge clock);
      end else begin
        repeat (PS2_HALF) @(negedge clock);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    kb_tr    = 1'b0;
    repeat (PS2_GAP) @(negedge clock);
  endtask

  task automatic popByte();
    kb_tr = 1'b1;
    repeat (2) @(negedge clock);
    kb_tr = 1'b0;
    repeat (2) @(negedge clock);
    if (model_q.size() > 0) void'(model_q.pop_front());
  endtask

  task automatic clearFlags();
    kb_clr = 1'b1;
    @(negedge clock);
    kb_clr = 1'b0;
    @(negedge clock);
    model_err = 1'b0;
    model_ovf = 1'b0;
  endtask

  // Bounds the whole run so a stuck design still ends with a report
  initial begin
    repeat (90000) @(posedge clock);
    $display("[TB] FAIL watchdog: run exceeded 90000 cycles, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized frames, pops and clears
  initial begin
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    kb_tr    = 1'b0;
    kb_clr   = 1'b0;
    modelReset();
    repeat (3) @(negedge clock);
    checkAll("reset");
    reset = 1'b0;
    repeat (20) @(negedge clock);
    checkAll("post_reset");

    applyStimulus(8'h1C, 1'b0, 1'b0, 2, 11);
    modelFrame(8'h1C, 1'b1, 1'b0);
    checkAll("good_1c");
    popByte();
    checkAll("pop_1c");

    applyStimulus(8'h1C, 1'b1, 1'b0, 0, 11);
    modelFrame(8'h1C, 1'b0, 1'b0);
    checkAll("bad_parity");
    clearFlags();
    checkAll("clr_err");

    for (int i = 1; i <= 9; i++) begin
      applyStimulus(8'(i), 1'b0, 1'b0, 0, 11);
      modelFrame(8'(i), 1'b1, 1'b0);
    end
    checkAll("overflow");
    for (int i = 1; i <= 8; i++) begin
      checkOutput("drain.ch", 32'(kb_ch), 32'(i));
      popByte();
    end
    checkAll("drained");
    clearFlags();

    applyStimulus(8'hA5, 1'b0, 1'b0, 0, 5);
    repeat (TIMEOUT + TIMEOUT / 4) @(negedge clock);
    model_err = 1'b1;
    checkAll("timeout");
    applyStimulus(8'hF0, 1'b0, 1'b0, 0, 11);
    modelFrame(8'hF0, 1'b1, 1'b0);
    checkAll("after_timeout");
    popByte();
    clearFlags();

    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    repeat (2) @(negedge clock);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (20) @(negedge clock);
    checkAll("glitch");
    applyStimulus(8'h5A, 1'b0, 1'b0, 0, 11);
    modelFrame(8'h5A, 1'b1, 1'b0);
    checkAll("after_glitch");
    popByte();

    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'h31 + 8'(i), 1'b0, 1'b0, 0, 11);
      modelFrame(8'h31 + 8'(i), 1'b1, 1'b0);
    end
    kb_tr = 1'b1;
    repeat (10) @(negedge clock);
    kb_tr = 1'b0;
    repeat (2) @(negedge clock);
    void'(model_q.pop_front());
    checkAll("held_tr");
    popByte();
    checkAll("held_tr_pop2");
    popByte();
    checkAll("held_tr_pop3");

    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(8'h40 + 8'(i), 1'b0, 1'b0, 0, 11);
      modelFrame(8'h40 + 8'(i), 1'b1, 1'b0);
    end
    applyStimulus(8'hE7, 1'b0, 1'b0, 1, 11);
    modelFrame(8'hE7, 1'b1, 1'b1);
    checkAll("full_push_pop");
    for (int i = 0; i < DEPTH; i++) begin
      checkAll("full_drain");
      popByte();
    end
    checkAll("full_empty");

    applyStimulus(8'h11, 1'b0, 1'b0, 0, 11);
    applyStimulus(8'h22, 1'b0, 1'b0, 0, 11);
    applyStimulus(8'h77, 1'b0, 1'b0, 0, 4);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    modelReset();
    checkAll("mid_reset");
    reset = 1'b0;
    repeat (20) @(negedge clock);
    applyStimulus(8'h3C, 1'b0, 1'b0, 0, 11);
    modelFrame(8'h3C, 1'b1, 1'b0);
    checkAll("after_reset");

    for (int n = 0; n < 40; n++) begin
      op       = $urandom_range(0, 11);
      rnd_byte = 8'($urandom);
      if (op <= 5) begin
        applyStimulus(rnd_byte, 1'b0, 1'b0, 0, 11);
        modelFrame(rnd_byte, 1'b1, 1'b0);
      end else if (op == 6) begin
        applyStimulus(rnd_byte, 1'b1, 1'b0, 0, 11);
        modelFrame(rnd_byte, 1'b0, 1'b0);
      end else if (op == 7) begin
        applyStimulus(rnd_byte, 1'b0, 1'b1, 0, 11);
        modelFrame(rnd_byte, 1'b0, 1'b0);
      end else if (op == 8) begin
        popByte();
      end else if (op == 9) begin
        clearFlags();
      end else begin
        applyStimulus(rnd_byte, 1'b0, 1'b0, 1, 11);
        modelFrame(rnd_byte, 1'b1, 1'b1);
      end
      checkAll("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
